// File: rtl/array_feeder_if.sv
// Row-vector handshake between the activation buffer and the feeder.
// One full vector moves per cycle where in_valid and in_ready are both high.
interface array_feeder_if #(
    parameter int LANES  = 256,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] in_data [0:LANES-1];

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/array_feeder.sv
// Skews accepted row vectors so lane i trails lane 0 by i cycles,
// then drains the skew pipeline after the last vector of a batch.
module array_feeder #(
    parameter int LANES  = 256,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    array_feeder_if.slave     in_if,
    output logic [DATA_W-1:0] left_out [0:LANES-1],
    output logic [LANES-1:0]  lane_valid,
    output logic              busy,
    output logic              done
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign in_if.in_ready = (state_q != S_DRAIN);
    assign accept         = in_if.in_valid && in_if.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_STREAM: begin
                if (accept) begin
                    if (in_if.in_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_LAST;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Triangular skew: lane i owns i+1 stages and shifts every cycle.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] data_q [0:i];
        logic [i:0]        vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j <= i; j++) data_q[j] <= '0;
                vld_q <= '0;
            end else begin
                data_q[0] <= accept ? in_if.in_data[i] : '0;
                vld_q[0]  <= accept;
                for (int j = 1; j <= i; j++) begin
                    data_q[j] <= data_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign left_out[i]   = data_q[i];
        assign lane_valid[i] = vld_q[i];
    end

    assign done = (state_q == S_DRAIN) && (cnt_q == '0);
    assign busy = (state_q != S_IDLE) || (|lane_valid);
endmodule

// File: tb/tb_array_feeder.sv
// Bench for array_feeder: vector tables, a history-based reference
// model under random traffic, reset/backpressure cases and a 256-lane run.
module tb_array_feeder;
    localparam int L  = 4;
    localparam int W  = 8;
    localparam int BL = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    array_feeder_if #(.LANES(L), .DATA_W(W)) ifa ();
    logic [W-1:0] lo [0:L-1];
    logic [L-1:0] lv;
    logic         busy, done;

    array_feeder #(.LANES(L), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .in_if(ifa),
        .left_out(lo), .lane_valid(lv), .busy(busy), .done(done)
    );

    array_feeder_if #(.LANES(BL), .DATA_W(W)) ifb ();
    logic [W-1:0]  lob [0:BL-1];
    logic [BL-1:0] lvb;
    logic          busyb, doneb;

    array_feeder #(.LANES(BL), .DATA_W(W)) dut_big (
        .clk(clk), .reset(reset), .in_if(ifb),
        .left_out(lob), .lane_valid(lvb), .busy(busyb), .done(doneb)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: per-edge history of accepted vectors.
    // Lane i after edge k shows whatever was accepted at edge k-i.
    logic [31:0] hd [$];
    bit          hv [$];
    int          n;
    int          last_e;
    bit          in_batch;
    int          done_seen;
    int          ff_seen;

    function automatic bit m_ready();
        int k;
        k = n - 1;
        return !(last_e >= 0 && k >= last_e && k <= last_e + L - 1);
    endfunction

    task automatic model_clear();
        hd.delete();
        hv.delete();
        n        = 0;
        last_e   = -1;
        in_batch = 1'b0;
    endtask

    task automatic step(input bit v, input bit l, input logic [31:0] d);
        bit          rdy, acc, exd, exb;
        logic [31:0] exl;
        logic [3:0]  exv;
        int          idx;
        rdy = m_ready();
        chk("in_ready", {31'd0, ifa.in_ready}, {31'd0, rdy});
        ifa.in_valid = v;
        ifa.in_last  = l;
        for (int i = 0; i < L; i++) ifa.in_data[i] = d[i*8 +: 8];
        acc = v && rdy;
        @(posedge clk);
        #1;
        hv.push_back(acc);
        hd.push_back(acc ? d : 32'd0);
        n++;
        if (acc) begin
            if (l) begin
                last_e   = n - 1;
                in_batch = 1'b0;
            end else begin
                in_batch = 1'b1;
            end
        end
        exl = '0;
        exv = '0;
        for (int i = 0; i < L; i++) begin
            idx = hv.size() - 1 - i;
            if (idx >= 0) begin
                exv[i]        = hv[idx];
                exl[i*8 +: 8] = hd[idx][i*8 +: 8];
            end
        end
        exd = (last_e >= 0) && (n - 1 == last_e + L - 1);
        exb = in_batch || !m_ready() || (|exv);
        for (int i = 0; i < L; i++)
            chk($sformatf("lane%0d_data", i), {24'd0, lo[i]},
                {24'd0, exl[i*8 +: 8]});
        chk("lane_valid", {28'd0, lv}, {28'd0, exv});
        chk("done", {31'd0, done}, {31'd0, exd});
        chk("busy", {31'd0, busy}, {31'd0, exb});
        if (done) done_seen++;
        for (int i = 0; i < L; i++) if (lo[i] == 8'hFF) ff_seen++;
    endtask

    task automatic do_reset();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < L; i++)
            chk("rst_lane_data", {24'd0, lo[i]}, 32'd0);
        chk("rst_lane_valid", {28'd0, lv}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #2 reset = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        bit          l;
        logic [31:0] d;
        logic [31:0] el;
        logic [3:0]  ev;
        bit          ed;
        bit          er;
    } vec_t;

    vec_t tbl [19];

    int c255, first255, last255, donek, dcount;
    bit busy510, busy511;

    initial begin
        // single vector {1,2,3,4} last
        tbl[0]  = '{1, 1, 1, 32'h04030201, 32'h00000001, 4'b0001, 0, 0};
        tbl[1]  = '{0, 0, 0, 32'h0,        32'h00000200, 4'b0010, 0, 0};
        tbl[2]  = '{0, 0, 0, 32'h0,        32'h00030000, 4'b0100, 0, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,        32'h04000000, 4'b1000, 1, 0};
        tbl[4]  = '{0, 0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 1};
        // back-to-back three vectors, 0xFF offered during drain
        tbl[5]  = '{1, 1, 0, 32'h04030201, 32'h00000001, 4'b0001, 0, 1};
        tbl[6]  = '{0, 1, 0, 32'h08070605, 32'h00000205, 4'b0011, 0, 1};
        tbl[7]  = '{0, 1, 1, 32'h0c0b0a09, 32'h00030609, 4'b0111, 0, 0};
        tbl[8]  = '{0, 1, 1, 32'hFFFFFFFF, 32'h04070a00, 4'b1110, 0, 0};
        tbl[9]  = '{0, 1, 1, 32'hFFFFFFFF, 32'h080b0000, 4'b1100, 0, 0};
        tbl[10] = '{0, 1, 1, 32'hFFFFFFFF, 32'h0c000000, 4'b1000, 1, 0};
        tbl[11] = '{0, 1, 1, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 0, 1};
        // A, bubble, B last
        tbl[12] = '{1, 1, 0, 32'h04030201, 32'h00000001, 4'b0001, 0, 1};
        tbl[13] = '{0, 0, 0, 32'h0,        32'h00000200, 4'b0010, 0, 1};
        tbl[14] = '{0, 1, 1, 32'h08070605, 32'h00030005, 4'b0101, 0, 0};
        tbl[15] = '{0, 0, 0, 32'h0,        32'h04000600, 4'b1010, 0, 0};
        tbl[16] = '{0, 0, 0, 32'h0,        32'h00070000, 4'b0100, 0, 0};
        tbl[17] = '{0, 0, 0, 32'h0,        32'h08000000, 4'b1000, 1, 0};
        tbl[18] = '{0, 0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 1};

        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
        for (int i = 0; i < L; i++) ifa.in_data[i] = '0;
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        for (int i = 0; i < BL; i++) ifb.in_data[i] = '0;
        model_clear();
        done_seen = 0;
        ff_seen   = 0;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int r = 0; r < 19; r++) begin
            if (tbl[r].rst) do_reset();
            step(tbl[r].v, tbl[r].l, tbl[r].d);
            chk($sformatf("tbl%0d_left", r),
                {lo[3], lo[2], lo[1], lo[0]}, tbl[r].el);
            chk($sformatf("tbl%0d_valid", r), {28'd0, lv}, {28'd0, tbl[r].ev});
            chk($sformatf("tbl%0d_done", r), {31'd0, done}, {31'd0, tbl[r].ed});
            chk($sformatf("tbl%0d_ready", r), {31'd0, ifa.in_ready},
                {31'd0, tbl[r].er});
        end

        // asynchronous reset with the drain counter at 2
        do_reset();
        step(1'b1, 1'b1, 32'h04030201);
        step(1'b0, 1'b0, 32'h0);
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < L; i++)
            chk("midrst_lane_data", {24'd0, lo[i]}, 32'd0);
        chk("midrst_lane_valid", {28'd0, lv}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        #2 reset = 1'b0;
        model_clear();
        chk("midrst_ready", {31'd0, ifa.in_ready}, 32'd1);
        step(1'b0, 1'b0, 32'h0);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 500; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 $urandom);
        repeat (L + 2) step(1'b0, 1'b0, 32'h0);

        // backpressure: 0xFF offered throughout drain
        do_reset();
        done_seen = 0;
        ff_seen   = 0;
        step(1'b1, 1'b0, 32'h11223344);
        step(1'b1, 1'b1, 32'h55667788);
        repeat (4) step(1'b1, 1'b1, 32'hFFFFFFFF);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("bp_done_pulses", done_seen, 32'd1);
        chk("bp_no_ff", ff_seen, 32'd0);

        // 256-lane batch, element value = lane index
        do_reset();
        chk("big_ready", {31'd0, ifb.in_ready}, 32'd1);
        for (int i = 0; i < BL; i++) ifb.in_data[i] = 8'(i);
        c255 = 0; first255 = -1; last255 = -1; donek = -1; dcount = 0;
        busy510 = 1'b0; busy511 = 1'b1;
        for (int k = 0; k < 516; k++) begin
            ifb.in_valid = (k < BL);
            ifb.in_last  = (k == BL - 1);
            @(posedge clk);
            #1;
            if (lvb[255] && lob[255] == 8'd255) begin
                c255++;
                if (first255 < 0) first255 = k;
                last255 = k;
            end
            if (doneb) begin
                dcount++;
                donek = k;
            end
            if (k == 510) busy510 = busyb;
            if (k == 511) busy511 = busyb;
        end
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        chk("big_lane255_cycles", c255, 32'd256);
        chk("big_lane255_first", first255, 32'd255);
        chk("big_lane255_last", last255, 32'd510);
        chk("big_done_count", dcount, 32'd1);
        chk("big_done_edge", donek, 32'd510);
        chk("big_busy_at_done", {31'd0, busy510}, 32'd1);
        chk("big_busy_after", {31'd0, busy511}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
